// File: rtl/scm_read_port_arbiter_pkg.sv
// Shared types, default geometry and helpers for the SCM read-port arbiter.
package scm_read_port_arbiter_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_N_READ     = 2;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    typedef logic [DEF_ADDR_WIDTH-1:0] scm_addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] scm_data_t;

    // Circular successor of a requestor index among n requestors.
    function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/scm_read_port_arbiter_if.sv
// Requestor-side and SCM-side signal bundle of the read-port arbiter.
interface scm_read_port_arbiter_if
    import scm_read_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned N_READ     = DEF_N_READ,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_REQ-1:0]            gnt_o;
    logic [NUM_REQ-1:0]            r_valid_o;
    logic [NUM_REQ*DATA_WIDTH-1:0] r_rdata_o;
    logic [N_READ-1:0]             ReadEnable;
    logic [N_READ*ADDR_WIDTH-1:0]  ReadAddr;
    logic [N_READ*DATA_WIDTH-1:0]  ReadData;

    // Arbiter view.
    modport slave (
        input  req_i, addr_i, ReadData,
        output gnt_o, r_valid_o, r_rdata_o, ReadEnable, ReadAddr
    );

    // Requestor + SCM environment view.
    modport master (
        output req_i, addr_i, ReadData,
        input  gnt_o, r_valid_o, r_rdata_o, ReadEnable, ReadAddr
    );

endinterface

// File: rtl/scm_read_port_arbiter_rr_select.sv
// Combinational circular priority scan: binds the first N_READ active
// requests found from the round-robin pointer onwards to ports 0..N_READ-1.
module scm_read_port_arbiter_rr_select
    import scm_read_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned N_READ  = DEF_N_READ,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [PTR_W-1:0]               i_rr_ptr,
    output logic [N_READ-1:0][NUM_REQ-1:0] o_port_gnt_c,
    output logic [N_READ-1:0][PTR_W-1:0]   o_port_idx_c,
    output logic [N_READ-1:0]              o_port_vld_c,
    output logic [PTR_W-1:0]               o_last_idx_c,
    output logic                           o_any_gnt_c
);

    localparam int unsigned CNT_W = $clog2(N_READ + 1);

    logic [PTR_W-1:0] w_idx;
    logic [CNT_W-1:0] w_cnt;

    // Walk requestors in circular order; the k-th hit takes port k.
    always_comb begin
        o_port_gnt_c = '0;
        o_port_idx_c = '0;
        o_port_vld_c = '0;
        o_last_idx_c = i_rr_ptr;
        w_idx        = i_rr_ptr;
        w_cnt        = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            if (i_req[w_idx] && (w_cnt < CNT_W'(N_READ))) begin
                for (int unsigned k = 0; k < N_READ; k++) begin
                    if (w_cnt == CNT_W'(k)) begin
                        o_port_gnt_c[k][w_idx] = 1'b1;
                        o_port_idx_c[k]        = w_idx;
                        o_port_vld_c[k]        = 1'b1;
                    end
                end
                o_last_idx_c = w_idx;
                w_cnt        = w_cnt + CNT_W'(1);
            end
            w_idx = PTR_W'(rr_next_idx(32'(w_idx), NUM_REQ));
        end
        o_any_gnt_c = |o_port_vld_c;
    end

endmodule

// File: rtl/scm_read_port_arbiter.sv
// Shares the N_READ read ports of a latch-based SCM among NUM_REQ requestors
// with round-robin arbitration and a fixed one-cycle read response.
module scm_read_port_arbiter
    import scm_read_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned N_READ     = DEF_N_READ,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    scm_read_port_arbiter_if.slave  rd_if
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [N_READ-1:0][NUM_REQ-1:0] w_port_gnt;
    logic [N_READ-1:0][PTR_W-1:0]   w_port_idx;
    logic [N_READ-1:0]              w_port_vld;
    logic [PTR_W-1:0]               w_last_idx;
    logic                           w_any_gnt;

    logic [PTR_W-1:0]               r_rr_ptr;
    logic [N_READ-1:0][PTR_W-1:0]   r_port_owner;
    logic [N_READ-1:0]              r_port_busy;

    scm_read_port_arbiter_rr_select #(
        .NUM_REQ (NUM_REQ),
        .N_READ  (N_READ),
        .PTR_W   (PTR_W)
    ) u_rr_select (
        .i_req        (rd_if.req_i),
        .i_rr_ptr     (r_rr_ptr),
        .o_port_gnt_c (w_port_gnt),
        .o_port_idx_c (w_port_idx),
        .o_port_vld_c (w_port_vld),
        .o_last_idx_c (w_last_idx),
        .o_any_gnt_c  (w_any_gnt)
    );

    // Grant and SCM port drive; everything held quiet while in reset.
    always_comb begin
        rd_if.gnt_o      = '0;
        rd_if.ReadEnable = '0;
        rd_if.ReadAddr   = '0;
        if (rst_n) begin
            for (int unsigned k = 0; k < N_READ; k++) begin
                rd_if.ReadEnable[k] = w_port_vld[k];
                for (int unsigned r = 0; r < NUM_REQ; r++) begin
                    if (w_port_gnt[k][r]) begin
                        rd_if.gnt_o[r] = 1'b1;
                        rd_if.ReadAddr[k*ADDR_WIDTH +: ADDR_WIDTH] =
                            rd_if.addr_i[r*ADDR_WIDTH +: ADDR_WIDTH];
                    end
                end
            end
        end
    end

    // Round-robin pointer moves past the last granted requestor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_any_gnt) begin
            r_rr_ptr <= PTR_W'(rr_next_idx(32'(w_last_idx), NUM_REQ));
        end
    end

    // Remember which requestor owns each port for the response cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_port_busy  <= '0;
            r_port_owner <= '0;
        end else begin
            r_port_busy <= w_port_vld;
            for (int unsigned k = 0; k < N_READ; k++) begin
                if (w_port_vld[k]) begin
                    r_port_owner[k] <= w_port_idx[k];
                end
            end
        end
    end

    // Route each busy port's ReadData back to its owner; idle lanes read zero.
    always_comb begin
        rd_if.r_valid_o = '0;
        rd_if.r_rdata_o = '0;
        for (int unsigned k = 0; k < N_READ; k++) begin
            for (int unsigned r = 0; r < NUM_REQ; r++) begin
                if (r_port_busy[k] && (r_port_owner[k] == PTR_W'(r))) begin
                    rd_if.r_valid_o[r] = 1'b1;
                    rd_if.r_rdata_o[r*DATA_WIDTH +: DATA_WIDTH] =
                        rd_if.ReadData[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule
